// File: rtl/trng_pkg.sv
// Shared types and sizing helpers for the TRNG request arbiter.
// Optional health test is enabled with the TRNG_HEALTH_EN macro (see trng_req_arbiter.sv).
package trng_pkg;

    // Width of one TRNG sample.
    localparam int BYTE_W = 8;

    // Arbiter sequencing: discard warm-up samples, serve requesters, or hold off after a health trip.
    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_FAIL   = 2'd2
    } state_t;

    // Bits needed to count 0..n-1; never less than one bit.
    // Used to size the decimation counter, warm-up counter, round-robin pointer and repetition counter.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/trng_rr_arbiter.sv
// Round-robin select: picks the first set request at or after the pointer, wrapping modulo NUM_REQ.
// Purely combinational; the parent registers the grant and advances the pointer.
module trng_rr_arbiter
    import trng_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = cnt_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

    logic [NUM_REQ-1:0] w_rot;
    logic [PTR_W-1:0]   w_off;
    logic [PTR_W:0]     w_sum;
    logic               w_any;

    // Rotate so the pointer position lands on bit 0.
    assign w_rot = NUM_REQ'({i_req, i_req} >> i_rr_ptr);

    // Lowest set bit of the rotated vector is the nearest requester at or after the pointer.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_off = '0;
        w_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = PTR_W'(k);
                w_any = 1'b1;
            end
        end
    end

    // Undo the rotation: winner = (pointer + offset) mod NUM_REQ.
    assign w_sum    = {1'b0, i_rr_ptr} + {1'b0, w_off};
    assign o_idx    = (w_sum >= (PTR_W+1)'(NUM_REQ)) ? PTR_W'(w_sum - (PTR_W+1)'(NUM_REQ))
                                                     : PTR_W'(w_sum);
    assign o_any    = w_any;
    assign o_onehot = w_any ? (NUM_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/trng_req_arbiter.sv
// Shares decimated TRNG samples among NUM_REQ requesters, one sample per grant, round-robin.
// A warm-up window of samples is discarded after reset.
// Define TRNG_HEALTH_EN to add a repetition-count health test with a sticky failure state.
module trng_req_arbiter
    import trng_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int SAMPLE_DIV     = 8,
    parameter int WARMUP_SAMPLES = 16,
    parameter int REP_LIMIT      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BYTE_W-1:0]  trng_byte,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [BYTE_W-1:0]  rnd_data,
    output logic               rnd_valid,
    output logic               ready,
    output logic               health_fail,
    input  logic               health_clr
);

    localparam int DIV_W  = cnt_w(SAMPLE_DIV);
    localparam int WARM_W = cnt_w(WARMUP_SAMPLES);
    localparam int PTR_W  = cnt_w(NUM_REQ);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_SAMPLES - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NUM_REQ - 1);

    state_t              r_state;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [WARM_W-1:0]   r_warm_cnt;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [BYTE_W-1:0]   r_hold;
    logic                r_fresh;
    logic [NUM_REQ-1:0]  r_gnt;
    logic                r_rnd_valid;
    logic [BYTE_W-1:0]   r_rnd_data;
    logic                r_ready;

    logic                w_strobe;
    logic [NUM_REQ-1:0]  w_onehot;
    logic [PTR_W-1:0]    w_idx;
    logic                w_any;
    logic [PTR_W-1:0]    w_ptr_next;

`ifdef TRNG_HEALTH_EN
    localparam int             REP_W    = cnt_w(REP_LIMIT);
    localparam logic [REP_W-1:0] REP_TRIP = REP_W'(REP_LIMIT - 2);

    logic                r_health_fail;
    logic [REP_W-1:0]    r_rep_cnt;
    logic [BYTE_W-1:0]   r_prev_sample;
    logic                w_rep_match;
    logic                w_trip;

    // A trip happens on the strobe that makes REP_LIMIT identical samples in a row.
    assign w_rep_match = (trng_byte == r_prev_sample);
    assign w_trip      = w_strobe && (r_state != ST_FAIL) && w_rep_match && (r_rep_cnt == REP_TRIP);
    assign health_fail = r_health_fail;
`else
    // Health test absent: no failure is ever reported and the clear input has no effect.
    logic w_unused;
    assign w_unused    = &{1'b0, health_clr, REP_LIMIT[0]};
    assign health_fail = 1'b0;
`endif

    assign w_strobe   = (r_div_cnt == DIV_LAST);
    assign w_ptr_next = (w_idx == PTR_LAST) ? '0 : w_idx + 1'b1;

    trng_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    // Decimation, sample capture, state sequencing and registered grant outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every branch reads pre-edge state.
        if (rst) begin
            r_state     <= ST_WARMUP;
            r_div_cnt   <= '0;
            r_warm_cnt  <= '0;
            r_rr_ptr    <= '0;
            r_hold      <= '0;
            r_fresh     <= 1'b0;
            r_gnt       <= '0;
            r_rnd_valid <= 1'b0;
            r_rnd_data  <= '0;
            r_ready     <= 1'b0;
`ifdef TRNG_HEALTH_EN
            r_health_fail <= 1'b0;
            r_rep_cnt     <= '0;
            r_prev_sample <= '0;
`endif
        end else begin
            r_div_cnt   <= w_strobe ? '0 : r_div_cnt + 1'b1;
            r_gnt       <= '0;
            r_rnd_valid <= 1'b0;

            // A new sample replaces any unconsumed one.
            if (w_strobe) begin
                r_hold  <= trng_byte;
                r_fresh <= 1'b1;
            end

            case (r_state)
                ST_WARMUP: begin
                    r_ready <= 1'b0;
                    if (w_strobe) begin
                        if (r_warm_cnt == WARM_LAST) begin
                            // The last warm-up sample is discarded along with the rest.
                            r_state    <= ST_RUN;
                            r_ready    <= 1'b1;
                            r_fresh    <= 1'b0;
                            r_warm_cnt <= '0;
                        end else begin
                            r_warm_cnt <= r_warm_cnt + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_ready <= 1'b1;
                    if (r_fresh && w_any) begin
                        r_gnt       <= w_onehot;
                        r_rnd_valid <= 1'b1;
                        r_rnd_data  <= r_hold;
                        r_rr_ptr    <= w_ptr_next;
                        // A sample landing on the same edge stays pending for the next grant.
                        if (!w_strobe) begin
                            r_fresh <= 1'b0;
                        end
                    end
                end
                ST_FAIL: begin
                    r_ready <= 1'b0;
`ifdef TRNG_HEALTH_EN
                    if (health_clr) begin
                        r_state       <= ST_WARMUP;
                        r_health_fail <= 1'b0;
                        r_warm_cnt    <= '0;
                        r_rep_cnt     <= '0;
                    end
`endif
                end
                default: begin
                    r_state <= ST_WARMUP;
                    r_ready <= 1'b0;
                end
            endcase

`ifdef TRNG_HEALTH_EN
            if (w_strobe && (r_state != ST_FAIL)) begin
                r_prev_sample <= trng_byte;
                r_rep_cnt     <= w_rep_match ? r_rep_cnt + 1'b1 : '0;
            end
            // Placed after the state case so a trip overrides any grant or warm-up exit on this edge.
            if (w_trip) begin
                r_state       <= ST_FAIL;
                r_health_fail <= 1'b1;
                r_ready       <= 1'b0;
                r_fresh       <= 1'b0;
                r_gnt         <= '0;
                r_rnd_valid   <= 1'b0;
                r_rnd_data    <= r_rnd_data;
                r_rr_ptr      <= r_rr_ptr;
            end
`endif
        end
    end

    assign gnt       = r_gnt;
    assign rnd_valid = r_rnd_valid;
    assign rnd_data  = r_rnd_data;
    assign ready     = r_ready;

endmodule

// File: tb/tb_trng_req_arbiter.sv
// Self-checking bench for trng_req_arbiter with default parameters.
// Expected grants (winner index and strobe phase) are queued as stimulus is applied and
// compared when the DUT raises rnd_valid; the delivered byte is checked against the
// most recent sample the bench saw at a decimation strobe.
// The health-test scenario runs only when TRNG_HEALTH_EN is defined.
module tb_trng_req_arbiter;

    localparam int NREQ = 4;
    localparam int SDIV = 8;
    localparam int WARM = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      trng_byte = 8'h00;
    logic [NREQ-1:0] req = '0;
    logic            health_clr = 1'b0;
    logic [NREQ-1:0] gnt;
    logic [7:0]      rnd_data;
    logic            rnd_valid;
    logic            ready;
    logic            health_fail;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         tb_div = 0;
    int         strobes = 0;
    logic [7:0] last_sample = 8'h00;
    bit         byte_hold = 1'b0;
    logic [7:0] hold_val = 8'hA5;

    typedef struct {
        int idx;
        int lat;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    trng_req_arbiter #(
        .NUM_REQ        (NREQ),
        .SAMPLE_DIV     (SDIV),
        .WARMUP_SAMPLES (WARM),
        .REP_LIMIT      (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trng_byte   (trng_byte),
        .req         (req),
        .gnt         (gnt),
        .rnd_data    (rnd_data),
        .rnd_valid   (rnd_valid),
        .ready       (ready),
        .health_fail (health_fail),
        .health_clr  (health_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // TRNG stand-in: a 7-bit cycle count (never 0xA5, never equal at consecutive strobes) or a held byte.
    always @(posedge clk) begin
        cyc++;
        #1;
        trng_byte = byte_hold ? hold_val : {1'b0, cyc[6:0]};
    end

    // Bench-side decimation: tracks the strobe phase and the latest strobed sample.
    always @(posedge clk) begin
        if (rst) begin
            tb_div  = 0;
            strobes = 0;
        end else if (tb_div == SDIV - 1) begin
            tb_div      = 0;
            strobes++;
            last_sample = trng_byte;
        end else begin
            tb_div++;
        end
    end

    // Output monitor: every grant must match the head of the expectation queue.
    always @(negedge clk) begin : mon
        exp_t e;
        if (gnt != '0 || rnd_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_gnt", 32'(gnt), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("gnt_onehot", 32'(gnt), 32'd1 << e.idx);
                check("rnd_valid", 32'(rnd_valid), 32'd1);
                check("rnd_data", 32'(rnd_data), 32'(last_sample));
                if (e.lat >= 0) check("gnt_phase", 32'(tb_div), 32'(e.lat));
            end
        end
    end

    task automatic push(input int idx, input int lat);
        exp_t e;
        e.idx = idx;
        e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic wait_div(input int d);
        int n = 0;
        @(negedge clk);
        while (tb_div != d && n < 2 * SDIV) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_empty(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Expects ready low until the bench has counted `target` strobes, then high.
    task automatic run_warmup(input string tag, input int target);
        int n = 0;
        while (strobes < target && n < 400) begin
            check({tag, "_ready_low"}, 32'(ready), 32'd0);
            @(negedge clk);
            n++;
        end
        check({tag, "_strobes"}, 32'(strobes), 32'(target));
        check({tag, "_ready_high"}, 32'(ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_rnd_valid"}, 32'(rnd_valid), 32'd0);
        check({tag, "_rnd_data"}, 32'(rnd_data), 32'd0);
        check({tag, "_ready"}, 32'(ready), 32'd0);
        check({tag, "_health_fail"}, 32'(health_fail), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int s0;
        int n;

        // Reset state with all requesters active.
        req = 4'b1111;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Warm-up: no grants and ready low until the 16th strobe.
        run_warmup("warmup", WARM);

        // Round-robin over all four, starting at pointer 0; first grant one edge after the 17th strobe.
        for (int i = 0; i < 8; i++) push(i % NREQ, 1);
        wait_empty("rr_all", 8 * SDIV + 20);

        // Alternate pair continues from pointer 0.
        wait_div(3);
        req = 4'b1010;
        push(1, 1); push(3, 1); push(1, 1); push(3, 1);
        wait_empty("rr_pair", 4 * SDIV + 20);

        // Single streamer: one byte per sample.
        wait_div(3);
        req = 4'b0001;
        for (int i = 0; i < 4; i++) push(0, 1);
        wait_empty("stream", 4 * SDIV + 20);

        // Stale overwrite: idle for three samples, then one requester gets only the newest.
        wait_div(3);
        req = 4'b0000;
        s0 = strobes;
        n = 0;
        while (strobes < s0 + 3 && n < 5 * SDIV) begin
            @(negedge clk);
            n++;
        end
        wait_div(3);
        req = 4'b0100;
        push(2, 4);
        push(2, 1);
        wait_empty("stale", 3 * SDIV);
        req = 4'b0000;

`ifdef TRNG_HEALTH_EN
        // Constant byte: three more grants (pointer at 3), then the fourth identical strobe trips.
        wait_div(3);
        byte_hold = 1'b1;
        req = 4'b1111;
        push(3, 1); push(0, 1); push(1, 1);
        wait_empty("pre_trip", 4 * SDIV + 20);
        wait_div(0);
        check("trip_health_fail", 32'(health_fail), 32'd1);
        check("trip_ready", 32'(ready), 32'd0);
        repeat (3 * SDIV) @(negedge clk);
        check("fail_sticky", 32'(health_fail), 32'd1);

        // Clear, then a full warm-up before ready returns.
        wait_div(3);
        byte_hold = 1'b0;
        req = 4'b0000;
        health_clr = 1'b1;
        @(negedge clk);
        health_clr = 1'b0;
        check("clr_health_fail", 32'(health_fail), 32'd0);
        check("clr_ready", 32'(ready), 32'd0);
        run_warmup("rewarm_clr", strobes + WARM);
`else
        check("health_off", 32'(health_fail), 32'd0);
`endif

        // Reset asserted in the cycle gnt[1] is high.
        wait_div(3);
        req = 4'b0010;
        push(1, -1);
        n = 0;
        while (gnt[1] !== 1'b1 && n < 3 * SDIV) begin
            @(negedge clk);
            n++;
        end
        check("mid_gnt_seen", 32'(gnt[1]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        exp_q.delete();
        run_warmup("rewarm_rst", WARM);
        push(1, 1);
        wait_empty("post_reset", 2 * SDIV + 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trng_req_arbiter.md
Name: trng_req_arbiter

Overview:
- Shares the TRNG `random_byte` output among NUM_REQ requesters.
- Samples the TRNG on a fixed decimation period and discards a warm-up window after reset.
- Hands each fresh sample to exactly one requester, chosen round-robin.
- Sits between the `trng` instance and on-chip consumers such as a UART streamer or a LFSR seeder.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SAMPLE_DIV, 8, clock cycles between TRNG samples (>=2).
- WARMUP_SAMPLES, 16, samples discarded after reset or health clear (>=1).
- REP_LIMIT, 4, consecutive identical samples that trip the health test (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- trng_byte  in  8  raw byte from `trng.random_byte`.
- req  in  NUM_REQ  per-requester request level.
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse.
- rnd_data  out  8  delivered byte; valid while rnd_valid=1.
- rnd_valid  out  1  high in the same cycle as any gnt bit.
- ready  out  1  high in RUN state.
- health_fail  out  1  sticky health-test failure.
- health_clr  in  1  clears a health failure.

Behaviour:
- Single clock domain; all outputs are registered.
- Reset (rst=1 at an edge): state=WARMUP; div_cnt, warm_cnt, rr_ptr, hold, fresh, rep_cnt all 0; gnt=0, rnd_valid=0, rnd_data=0x00, ready=0, health_fail=0.
- Reset mid-operation drops any pending byte and grant. Outputs are zero in the cycle after the reset edge.
- Decimation: div_cnt counts 0..SAMPLE_DIV-1 and wraps. strobe = (div_cnt==SAMPLE_DIV-1). It runs in every state.
- On strobe: hold<=trng_byte, fresh<=1. An unconsumed older byte is silently overwritten; each sample is delivered at most once.
- States: WARMUP, RUN, FAIL.
  - WARMUP: no grants, ready=0. warm_cnt increments per strobe. When the WARMUP_SAMPLES-th strobe occurs, go to RUN and clear fresh, so no warm-up sample is ever delivered.
  - RUN: ready=1. At an edge where fresh=1 and |req:
    - winner = first set req bit at or after rr_ptr, modulo NUM_REQ.
    - gnt<=onehot(winner), rnd_valid<=1, rnd_data<=hold, fresh<=0.
    - rr_ptr<=(winner+1) mod NUM_REQ.
    - Otherwise gnt<=0 and rnd_valid<=0; rnd_data holds its last value.
  - FAIL: see Optional Feature.
- Latency: grant is registered one edge after fresh is seen set. Best case, gnt is visible 2 cycles after the strobe cycle.
- Simultaneous strobe and grant at the same edge: the grant delivers the old hold value, the new sample is latched, and fresh stays 1.
- Requester protocol:
  - Holding req high yields one byte per fresh sample it wins (streaming).
  - Dropping req before a grant is legal; no state is kept per requester.
  - req bits are sampled only at grant decisions.
- With no requests, rr_ptr is unchanged.

Optional Feature:
- Macro: TRNG_HEALTH_EN.
- With the macro defined:
  - Repetition-count test on every strobe, in all states except FAIL.
  - If trng_byte==prev_sample then rep_cnt++, else rep_cnt<=0. prev_sample is updated on each strobe.
  - When rep_cnt reaches REP_LIMIT-1 (REP_LIMIT identical consecutive samples): go to FAIL, set health_fail=1, clear ready and fresh, and block all grants.
  - In FAIL, health_clr=1 at an edge: go to WARMUP, clear health_fail, warm_cnt and rep_cnt. A full warm-up is then required.
  - health_clr outside FAIL is ignored.
- Without the macro: health_fail is tied 0, health_clr is unused, FAIL is unreachable, and no rep_cnt or prev_sample registers exist.

Decomposition:
- Package trng_pkg holds:
  - state enum (WARMUP, RUN, FAIL);
  - counter width helpers as localparam functions (clog2 of SAMPLE_DIV, WARMUP_SAMPLES, NUM_REQ);
  - the byte width constant (8).
- One sub-module, trng_rr_arbiter: combinational priority-from-pointer select plus a valid flag.
  - Inputs: req and rr_ptr. Outputs: one-hot winner, winner index, any.
  - The parent registers gnt and rr_ptr.

Test Plan:
- Warm-up: defaults, req=4'b1111, trng_byte changing every cycle, reset released at cycle 0 → no gnt and ready=0 through cycle 127; ready=1 after the 16th strobe (edge at cycle 128); first gnt within 2 cycles of the 17th strobe.
- Single streamer: req=4'b0001 held, bench drives trng_byte = cycle count → gnt[0] pulses once every 8 cycles; each rnd_data equals trng_byte at the preceding strobe; rnd_valid coincides with gnt.
- Round-robin fairness: req=4'b1111 held → grant order 0,1,2,3,0,1 across consecutive samples. Then req=4'b1010 → order continues 1,3,1,3 from the current rr_ptr.
- Stale overwrite: req=0 for 3 sample periods, then req[2]=1 → exactly one gnt[2], carrying the most recent sample only; the next gnt waits for the following strobe.
- Health (TRNG_HEALTH_EN): trng_byte held 0xA5 in RUN → after 4 identical strobes health_fail=1, ready=0, and gnt stays 0 despite req=4'b1111. Pulse health_clr with varying trng_byte → health_fail=0 and ready returns 16 strobes later.
- Reset mid-grant: assert rst in the cycle gnt[1]=1 → the next cycle shows gnt=0, rnd_valid=0, rnd_data=0x00, ready=0, and warm-up restarts in full.
